// File: rtl/gfx_wbm_rwq.sv
// Texture request queue that masters a 256-bit Wishbone-style command bus with tagged, out-of-order completions.
// Optional read merging into an outstanding slot is enabled by defining GFX_WBM_MERGE_EN.

package gfx_wbm_pkg;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [31:0]  sel;
        logic [31:0]  adr;
        logic [255:0] dat;
        logic [7:0]   tid;
        logic [3:0]   cid;
        logic [1:0]   bte;
        logic [2:0]   cti;
    } wb_cmd_request256_t;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic         rty;
        logic [7:0]   tid;
        logic [255:0] dat;
    } wb_cmd_response256_t;
endpackage

module gfx_wbm_rwq
    import gfx_wbm_pkg::*;
#(
    parameter logic [3:0] CID         = 4'd5,
    parameter int         BUF_ENTRIES = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output wb_cmd_request256_t  wbm_req,
    input  wb_cmd_response256_t wbm_resp,
    output logic                sint_o,
    input  logic                read_request_i,
    input  logic                write_request_i,
    output logic                req_ready_o,
    input  logic [31:0]         texture_addr_i,
    input  logic [31:0]         texture_sel_i,
    input  logic [255:0]        texture_dat_i,
    output logic [255:0]        texture_dat_o,
    output logic                texture_data_ack,
    output logic [2:0]          texture_tag_o
);

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_PEND   = 2'd1,
        SLOT_POSTED = 2'd2
    } slot_state_e;

    slot_state_e        slotState_q [BUF_ENTRIES];
    slot_state_e        slotState_d [BUF_ENTRIES];
    logic               slotWe_q    [BUF_ENTRIES];
    logic               slotWe_d    [BUF_ENTRIES];
    logic [31:0]        slotSel_q   [BUF_ENTRIES];
    logic [31:0]        slotSel_d   [BUF_ENTRIES];
    logic [31:0]        slotAdr_q   [BUF_ENTRIES];
    logic [31:0]        slotAdr_d   [BUF_ENTRIES];
    logic [255:0]       slotDat_q   [BUF_ENTRIES];
    logic [255:0]       slotDat_d   [BUF_ENTRIES];
    logic [2:0]         busSlot_q, busSlot_d;
    wb_cmd_request256_t wbmReq_q, wbmReq_d;
    logic               dataAck_q, dataAck_d;
    logic [2:0]         tag_q, tag_d;
    logic [255:0]       datOut_q, datOut_d;
`ifdef GFX_WBM_MERGE_EN
    logic [2:0]         mergeCnt_q  [BUF_ENTRIES];
    logic [2:0]         mergeCnt_d  [BUF_ENTRIES];
    logic               replay_q    [BUF_ENTRIES];
    logic               replay_d    [BUF_ENTRIES];
    logic               anyReplay;
    logic [2:0]         replayIdx;
    logic [2:0]         mergeIdx;
`endif

    logic        strobe;
    logic        anyFree;
    logic        anyPend;
    logic        cplHit;
    logic        mergeHit;
    logic [2:0]  freeIdx;
    logic [2:0]  pendIdx;
    logic [2:0]  cplIdx;
    logic [31:0] alignedAdr;

    always_comb begin
        logic cplCand;

        strobe     = read_request_i | write_request_i;
        alignedAdr = texture_addr_i & ~32'h0000_001F;

        anyFree  = 1'b0;
        freeIdx  = '0;
        anyPend  = 1'b0;
        pendIdx  = '0;
        cplHit   = 1'b0;
        cplIdx   = '0;
        cplCand  = 1'b0;
        mergeHit = 1'b0;
`ifdef GFX_WBM_MERGE_EN
        anyReplay = 1'b0;
        replayIdx = '0;
        mergeIdx  = '0;
`endif

        // Scanning downwards leaves the lowest matching index in each search result.
        for (int n = BUF_ENTRIES - 1; n >= 0; n--) begin
            if (slotState_q[n] == SLOT_FREE) begin
                anyFree = 1'b1;
                freeIdx = 3'(n);
            end
            if (slotState_q[n] == SLOT_PEND) begin
                anyPend = 1'b1;
                pendIdx = 3'(n);
            end
`ifdef GFX_WBM_MERGE_EN
            if (replay_q[n]) begin
                anyReplay = 1'b1;
                replayIdx = 3'(n);
            end
`endif
        end

        for (int n = 0; n < BUF_ENTRIES; n++) begin
            cplCand = (wbm_resp.ack || wbm_resp.err) && (slotState_q[n] == SLOT_POSTED) &&
                      (wbm_resp.tid == {CID, 1'b0, 3'(n)});
`ifdef GFX_WBM_MERGE_EN
            if (replay_q[n]) begin
                cplCand = 1'b0;
            end
`endif
            if (cplCand) begin
                cplHit = 1'b1;
                cplIdx = 3'(n);
            end
        end

`ifdef GFX_WBM_MERGE_EN
        // A slot completing this very cycle cannot absorb a merge: its pulses are already being counted.
        for (int n = BUF_ENTRIES - 1; n >= 0; n--) begin
            if (read_request_i && !write_request_i && (slotState_q[n] != SLOT_FREE) &&
                !slotWe_q[n] && (slotAdr_q[n] == alignedAdr) && !replay_q[n] &&
                (mergeCnt_q[n] != 3'd7) && !(cplHit && (cplIdx == 3'(n)))) begin
                mergeHit = 1'b1;
                mergeIdx = 3'(n);
            end
        end
`endif

        req_ready_o = anyFree | mergeHit;

        slotState_d = slotState_q;
        slotWe_d    = slotWe_q;
        slotSel_d   = slotSel_q;
        slotAdr_d   = slotAdr_q;
        slotDat_d   = slotDat_q;
        busSlot_d   = busSlot_q;
        wbmReq_d    = '0;
        dataAck_d   = 1'b0;
        tag_d       = tag_q;
        datOut_d    = datOut_q;
`ifdef GFX_WBM_MERGE_EN
        mergeCnt_d  = mergeCnt_q;
        replay_d    = replay_q;
`endif

        // The bus carries a request for exactly one cycle; its slot stays PEND until rty is known.
        if (wbmReq_q.cyc) begin
            for (int n = 0; n < BUF_ENTRIES; n++) begin
                if (3'(n) == busSlot_q) begin
                    slotState_d[n] = wbm_resp.rty ? SLOT_PEND : SLOT_POSTED;
                end
            end
        end else if (anyPend) begin
            busSlot_d    = pendIdx;
            wbmReq_d.cyc = 1'b1;
            wbmReq_d.stb = 1'b1;
            wbmReq_d.tid = {CID, 1'b0, pendIdx};
            wbmReq_d.cid = CID;
            wbmReq_d.bte = WB_BTE_LINEAR;
            wbmReq_d.cti = WB_CTI_CLASSIC;
            for (int n = 0; n < BUF_ENTRIES; n++) begin
                if (3'(n) == pendIdx) begin
                    wbmReq_d.we  = slotWe_q[n];
                    wbmReq_d.sel = slotSel_q[n];
                    wbmReq_d.adr = slotAdr_q[n];
                    wbmReq_d.dat = slotDat_q[n];
                end
            end
        end

        if (cplHit) begin
            dataAck_d = 1'b1;
            tag_d     = cplIdx;
            datOut_d  = wbm_resp.dat;
            for (int n = 0; n < BUF_ENTRIES; n++) begin
                if (3'(n) == cplIdx) begin
`ifdef GFX_WBM_MERGE_EN
                    if (mergeCnt_q[n] != 3'd0) begin
                        replay_d[n]  = 1'b1;
                        slotDat_d[n] = wbm_resp.dat;
                    end else begin
                        slotState_d[n] = SLOT_FREE;
                    end
`else
                    slotState_d[n] = SLOT_FREE;
`endif
                end
            end
        end
`ifdef GFX_WBM_MERGE_EN
        else if (anyReplay) begin
            dataAck_d = 1'b1;
            tag_d     = replayIdx;
            for (int n = 0; n < BUF_ENTRIES; n++) begin
                if (3'(n) == replayIdx) begin
                    datOut_d      = slotDat_q[n];
                    mergeCnt_d[n] = mergeCnt_q[n] - 3'd1;
                    if (mergeCnt_q[n] == 3'd1) begin
                        replay_d[n]    = 1'b0;
                        slotState_d[n] = SLOT_FREE;
                    end
                end
            end
        end
`endif

        // Allocation only looks at slots already FREE at the start of the cycle.
`ifdef GFX_WBM_MERGE_EN
        if (strobe && mergeHit) begin
            for (int n = 0; n < BUF_ENTRIES; n++) begin
                if (3'(n) == mergeIdx) begin
                    mergeCnt_d[n] = mergeCnt_q[n] + 3'd1;
                end
            end
        end else
`endif
        if (strobe && anyFree) begin
            for (int n = 0; n < BUF_ENTRIES; n++) begin
                if (3'(n) == freeIdx) begin
                    slotState_d[n] = SLOT_PEND;
                    slotWe_d[n]    = write_request_i;
                    slotSel_d[n]   = texture_sel_i;
                    slotAdr_d[n]   = alignedAdr;
                    slotDat_d[n]   = texture_dat_i;
`ifdef GFX_WBM_MERGE_EN
                    mergeCnt_d[n]  = 3'd0;
                    replay_d[n]    = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < BUF_ENTRIES; n++) begin
                slotState_q[n] <= SLOT_FREE;
                slotWe_q[n]    <= 1'b0;
                slotSel_q[n]   <= '0;
                slotAdr_q[n]   <= '0;
                slotDat_q[n]   <= '0;
`ifdef GFX_WBM_MERGE_EN
                mergeCnt_q[n]  <= '0;
                replay_q[n]    <= 1'b0;
`endif
            end
            busSlot_q <= '0;
            wbmReq_q  <= '0;
            dataAck_q <= 1'b0;
            tag_q     <= '0;
            datOut_q  <= '0;
        end else begin
            slotState_q <= slotState_d;
            slotWe_q    <= slotWe_d;
            slotSel_q   <= slotSel_d;
            slotAdr_q   <= slotAdr_d;
            slotDat_q   <= slotDat_d;
`ifdef GFX_WBM_MERGE_EN
            mergeCnt_q  <= mergeCnt_d;
            replay_q    <= replay_d;
`endif
            busSlot_q   <= busSlot_d;
            wbmReq_q    <= wbmReq_d;
            dataAck_q   <= dataAck_d;
            tag_q       <= tag_d;
            datOut_q    <= datOut_d;
        end
    end

    assign wbm_req          = wbmReq_q;
    assign sint_o           = wbm_resp.err;
    assign texture_data_ack = dataAck_q;
    assign texture_tag_o    = tag_q;
    assign texture_dat_o    = datOut_q;

endmodule

// File: tb/tb_gfx_wbm_rwq.sv
// Testbench for gfx_wbm_rwq: cycle vector table, reset/merge sequences, and randomized traffic against a slot-level model.

module tb_gfx_wbm_rwq;
    import gfx_wbm_pkg::*;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  sel;
        logic         ack;
        logic         err;
        logic         rty;
        logic [7:0]   tid;
        logic [255:0] rdat;
        logic         expReady;
        logic         expSint;
        logic         expCyc;
        logic [7:0]   expTid;
        logic [31:0]  expAdr;
        logic         expAck;
        logic [2:0]   expTag;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    wb_cmd_request256_t  wbmReq;
    wb_cmd_response256_t wbmResp;
    logic                sint;
    logic                readReq;
    logic                writeReq;
    logic                reqReady;
    logic [31:0]         texAddr;
    logic [31:0]         texSel;
    logic [255:0]        texDatIn;
    logic [255:0]        texDatOut;
    logic                dataAck;
    logic [2:0]          tag;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    int           mState [4];
    logic         mWe    [4];
    logic [31:0]  mSel   [4];
    logic [31:0]  mAdr   [4];
    logic [255:0] mDat   [4];
    bit           busActive;
    int           busSlot;

    always #5 clk = ~clk;

    gfx_wbm_rwq #(.CID(4'd5), .BUF_ENTRIES(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .wbm_req          (wbmReq),
        .wbm_resp         (wbmResp),
        .sint_o           (sint),
        .read_request_i   (readReq),
        .write_request_i  (writeReq),
        .req_ready_o      (reqReady),
        .texture_addr_i   (texAddr),
        .texture_sel_i    (texSel),
        .texture_dat_i    (texDatIn),
        .texture_dat_o    (texDatOut),
        .texture_data_ack (dataAck),
        .texture_tag_o    (tag)
    );

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] sel,
                                 input logic ack, input logic err, input logic rty, input logic [7:0] tid,
                                 input logic [255:0] rdat);
        readReq     = rd;
        writeReq    = wr;
        texAddr     = addr;
        texSel      = sel;
        texDatIn    = {8{addr}};
        wbmResp.ack = ack;
        wbmResp.err = err;
        wbmResp.rty = rty;
        wbmResp.tid = tid;
        wbmResp.dat = rdat;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void addVec(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] sel,
                                   input logic ack, input logic err, input logic rty, input logic [7:0] tid,
                                   input logic [255:0] rdat, input logic eRdy, input logic eSint, input logic eCyc,
                                   input logic [7:0] eTid, input logic [31:0] eAdr, input logic eAck,
                                   input logic [2:0] eTag);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.sel = sel;
        v.ack = ack; v.err = err; v.rty = rty; v.tid = tid; v.rdat = rdat;
        v.expReady = eRdy; v.expSint = eSint; v.expCyc = eCyc; v.expTid = eTid; v.expAdr = eAdr;
        v.expAck = eAck; v.expTag = eTag;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [255:0] patA5;
        patA5 = {32{8'hA5}};

        // Single read, four-deep fill with refusal, out-of-order completion, stray tids, write with retry, err completion.
        addVec(1,0,32'h1000_0040,32'hFFFF_FFFF, 0,0,0,8'h00,'0,            1,0,0,8'h00,32'h0,          0,0);
        addVec(0,0,32'h0,32'h0,                 0,0,0,8'h00,'0,            1,0,1,8'h50,32'h1000_0040,  0,0);
        addVec(0,0,32'h0,32'h0,                 0,0,0,8'h00,'0,            1,0,0,8'h00,32'h0,          0,0);
        addVec(0,0,32'h0,32'h0,                 1,0,0,8'h50,patA5,         1,0,0,8'h00,32'h0,          1,0);
        addVec(0,0,32'h0,32'h0,                 0,0,0,8'h00,'0,            1,0,0,8'h00,32'h0,          0,0);
        addVec(1,0,32'h1000_0100,32'h0000_FFFF, 0,0,0,8'h00,'0,            1,0,0,8'h00,32'h0,          0,0);
        addVec(1,0,32'h1000_0200,32'h0000_FFFF, 0,0,0,8'h00,'0,            1,0,1,8'h50,32'h1000_0100,  0,0);
        addVec(1,0,32'h1000_0300,32'h0000_FFFF, 0,0,0,8'h00,'0,            1,0,0,8'h00,32'h0,          0,0);
        addVec(1,0,32'h1000_0400,32'h0000_FFFF, 0,0,0,8'h00,'0,            1,0,1,8'h51,32'h1000_0200,  0,0);
        addVec(1,0,32'h1000_0500,32'h0000_FFFF, 0,0,0,8'h00,'0,            0,0,0,8'h00,32'h0,          0,0);
        addVec(0,0,32'h0,32'h0,                 0,0,0,8'h00,'0,            0,0,1,8'h52,32'h1000_0300,  0,0);
        addVec(0,0,32'h0,32'h0,                 0,0,0,8'h00,'0,            0,0,0,8'h00,32'h0,          0,0);
        addVec(1,0,32'h1000_0600,32'h0000_FFFF, 1,0,0,8'h52,{32{8'h33}},   0,0,1,8'h53,32'h1000_0400,  1,2);
        addVec(0,0,32'h0,32'h0,                 0,0,0,8'h00,'0,            1,0,0,8'h00,32'h0,          0,0);
        addVec(0,0,32'h0,32'h0,                 1,0,0,8'h51,{32{8'h11}},   1,0,0,8'h00,32'h0,          1,1);
        addVec(0,0,32'h0,32'h0,                 1,0,0,8'h50,{32{8'h22}},   1,0,0,8'h00,32'h0,          1,0);
        addVec(0,0,32'h0,32'h0,                 1,0,0,8'h52,{32{8'h44}},   1,0,0,8'h00,32'h0,          0,0);
        addVec(0,0,32'h0,32'h0,                 1,0,0,8'h53,{32{8'h55}},   1,0,0,8'h00,32'h0,          1,3);
        addVec(0,1,32'h3000_0004,32'h0000_000F, 1,0,0,8'h60,{32{8'h5A}},   1,0,0,8'h00,32'h0,          0,0);
        addVec(0,0,32'h0,32'h0,                 0,0,0,8'h00,'0,            1,0,1,8'h50,32'h3000_0000,  0,0);
        addVec(0,0,32'h0,32'h0,                 0,0,1,8'h00,'0,            1,0,0,8'h00,32'h0,          0,0);
        addVec(0,0,32'h0,32'h0,                 0,0,0,8'h00,'0,            1,0,1,8'h50,32'h3000_0000,  0,0);
        addVec(0,0,32'h0,32'h0,                 0,0,0,8'h00,'0,            1,0,0,8'h00,32'h0,          0,0);
        addVec(0,0,32'h0,32'h0,                 0,1,0,8'h50,{32{8'h66}},   1,1,0,8'h00,32'h0,          1,0);
        addVec(0,0,32'h0,32'h0,                 0,0,0,8'h00,'0,            1,0,0,8'h00,32'h0,          0,0);

        rst = 1'b1;
        idle();
        repeat (2) step();
        checkOutput("reset cyc", wbmReq.cyc, 1'b0);
        checkOutput("reset req zero", (wbmReq == '0), 1'b1);
        checkOutput("reset ack", dataAck, 1'b0);
        checkOutput("reset tag", tag, 3'd0);
        checkOutput("reset dat", texDatOut, '0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].sel, vecs[i].ack, vecs[i].err,
                          vecs[i].rty, vecs[i].tid, vecs[i].rdat);
            #2;
            checkOutput($sformatf("v%0d ready", i), reqReady, vecs[i].expReady);
            checkOutput($sformatf("v%0d sint", i), sint, vecs[i].expSint);
            step();
            checkOutput($sformatf("v%0d cyc", i), wbmReq.cyc, vecs[i].expCyc);
            if (vecs[i].expCyc) begin
                checkOutput($sformatf("v%0d stb", i), wbmReq.stb, 1'b1);
                checkOutput($sformatf("v%0d tid", i), wbmReq.tid, vecs[i].expTid);
                checkOutput($sformatf("v%0d adr", i), wbmReq.adr, vecs[i].expAdr);
            end
            checkOutput($sformatf("v%0d ack", i), dataAck, vecs[i].expAck);
            if (vecs[i].expAck) begin
                checkOutput($sformatf("v%0d tag", i), tag, vecs[i].expTag);
                checkOutput($sformatf("v%0d dat", i), texDatOut, vecs[i].rdat);
            end
        end

        // Three reads left POSTED, then reset: no pulses, everything free, stale acks ignored.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h4000_0000 + 32'(i) * 32'h100, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'h00, '0);
            step();
        end
        idle();
        repeat (5) step();
        checkOutput("pre-reset ready", reqReady, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h50, {32{8'h99}});
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("in-reset ack", dataAck, 1'b0);
            checkOutput("in-reset cyc", wbmReq.cyc, 1'b0);
            checkOutput("in-reset dat", texDatOut, '0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h51, {32{8'h98}});
        #2;
        checkOutput("post-reset ready", reqReady, 1'b1);
        step();
        checkOutput("post-reset stale ack", dataAck, 1'b0);
        checkOutput("post-reset cyc", wbmReq.cyc, 1'b0);
        idle();
        step();

`ifdef GFX_WBM_MERGE_EN
        // Two reads to the same 32-byte line share one bus request and yield two pulses.
        applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'h00, '0);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_2010, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'h00, '0);
        #2;
        checkOutput("merge ready", reqReady, 1'b1);
        step();
        checkOutput("merge issue cyc", wbmReq.cyc, 1'b1);
        checkOutput("merge issue tid", wbmReq.tid, 8'h50);
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("merge single request", wbmReq.cyc, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h50, {32{8'h77}});
        step();
        idle();
        checkOutput("merge pulse1", dataAck, 1'b1);
        checkOutput("merge pulse1 tag", tag, 3'd0);
        checkOutput("merge pulse1 dat", texDatOut, {32{8'h77}});
        step();
        checkOutput("merge pulse2", dataAck, 1'b1);
        checkOutput("merge pulse2 dat", texDatOut, {32{8'h77}});
        step();
        checkOutput("merge pulse end", dataAck, 1'b0);
        checkOutput("merge slot freed", reqReady, 1'b1);
`endif

        // Randomized traffic against a slot model built from the queue rules.
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) mState[s] = 0;
        busActive = 1'b0;
        busSlot   = 0;
        for (int c = 0; c < 600; c++) begin
            logic         rd, wr, ack, err, rty, expReady, expAck;
            logic [31:0]  addr, sel;
            logic [7:0]   tid;
            logic [255:0] rdat, expDat;
            logic [2:0]   expTag;
            int           oldState [4];
            int           idx;

            rd   = ($urandom_range(0, 2) == 0);
            wr   = ($urandom_range(0, 3) == 0);
`ifdef GFX_WBM_MERGE_EN
            rd   = 1'b0;
`endif
            addr = $urandom();
            sel  = $urandom();
            rdat = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            ack  = ($urandom_range(0, 1) == 0);
            err  = ack && ($urandom_range(0, 4) == 0);
            ack  = ack && !err;
            rty  = ($urandom_range(0, 3) == 0);
            idx  = $urandom_range(0, 4);
            tid  = {(($urandom_range(0, 9) == 0) ? 4'd6 : 4'd5), 1'b0, 3'(idx)};
            applyStimulus(rd, wr, addr, sel, ack, err, rty, tid, rdat);

            expReady = 1'b0;
            for (int s = 0; s < 4; s++) if (mState[s] == 0) expReady = 1'b1;
            #2;
            checkOutput("rand ready", reqReady, expReady);
            checkOutput("rand sint", sint, err);

            oldState = mState;
            expAck   = 1'b0;
            expTag   = '0;
            expDat   = '0;
            if ((ack || err) && tid[7:3] == 5'b0101_0 && idx < 4 && oldState[idx] == 2) begin
                mState[idx] = 0;
                expAck = 1'b1;
                expTag = 3'(idx);
                expDat = rdat;
            end
            if (busActive) begin
                mState[busSlot] = rty ? 1 : 2;
                busActive = 1'b0;
            end else begin
                for (int s = 3; s >= 0; s--) begin
                    if (oldState[s] == 1) begin
                        busActive = 1'b1;
                        busSlot   = s;
                    end
                end
            end
            if ((rd || wr) && expReady) begin
                int f;
                f = -1;
                for (int s = 3; s >= 0; s--) if (oldState[s] == 0) f = s;
                if (f >= 0) begin
                    mState[f] = 1;
                    mWe[f]    = wr;
                    mSel[f]   = sel;
                    mAdr[f]   = addr & ~32'h1F;
                    mDat[f]   = {8{addr}};
                end
            end

            step();
            checkOutput("rand cyc", wbmReq.cyc, busActive);
            if (busActive) begin
                checkOutput("rand tid", wbmReq.tid, {4'd5, 1'b0, 3'(busSlot)});
                checkOutput("rand adr", wbmReq.adr, mAdr[busSlot]);
                checkOutput("rand we", wbmReq.we, mWe[busSlot]);
                checkOutput("rand sel", wbmReq.sel, mSel[busSlot]);
                checkOutput("rand wdat", wbmReq.dat, mDat[busSlot]);
            end
            checkOutput("rand ack", dataAck, expAck);
            if (expAck) begin
                checkOutput("rand tag", tag, expTag);
                checkOutput("rand dat", texDatOut, expDat);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gfx_wbm_rwq.md
GFX_WBM_RWQ -- requirements
Module: gfx_wbm_rwq

Interface
REQ-001 Parameter CID, default 4'd5, bus client ID placed in every request.
REQ-002 Parameter BUF_ENTRIES, default 4, number of outstanding-request slots; legal range 1..8.
REQ-003 clk_i  input  1  master clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 wbm_req  output  wb_cmd_request256_t  registered bus request.
REQ-006 wbm_resp  input  wb_cmd_response256_t  bus response: ack, err, rty, tid, dat.
REQ-007 sint_o  output  1  error interrupt; equals wbm_resp.err.
REQ-008 read_request_i  input  1  read request strobe.
REQ-009 write_request_i  input  1  write request strobe; has priority when both strobes are high.
REQ-010 req_ready_o  output  1  high when the request can be accepted this cycle.
REQ-011 texture_addr_i  input  32  byte address.
REQ-012 texture_sel_i  input  32  byte-lane select.
REQ-013 texture_dat_i  input  256  write data.
REQ-014 texture_dat_o  output  256  read data, registered.
REQ-015 texture_data_ack  output  1  one-cycle completion pulse.
REQ-016 texture_tag_o  output  3  slot index of the completing request, valid with texture_data_ack.

Function
REQ-017 Each slot shall hold state FREE, PEND or POSTED, plus we, sel, 32-byte-aligned address ({addr[31:5],5'd0}) and data.
REQ-018 req_ready_o shall be high iff at least one slot is FREE at the start of the cycle, or a merge hit exists (REQ-028).
REQ-019 A strobe with req_ready_o high shall load the lowest-index FREE slot into PEND; strobes with req_ready_o low shall be ignored.
REQ-020 Slot n tid shall be {CID,1'b0,n[2:0]}; cid = CID, bte = LINEAR, cti = CLASSIC.
REQ-021 Issue: when wbm_req.cyc is low, the lowest-index PEND slot shall be driven on wbm_req with cyc = stb = 1 on the next cycle.
REQ-022 The issued request shall remain on the bus for exactly one cycle, then cyc and stb shall drop.
REQ-023 rty high during the issue cycle shall return the slot to PEND; otherwise the slot shall move to POSTED.
REQ-024 ack with tid matching a POSTED slot shall free that slot, pulse texture_data_ack next cycle, and register wbm_resp.dat into texture_dat_o and the slot index into texture_tag_o.
REQ-025 err with matching tid shall behave as ack (slot freed, pulse issued); sint_o is asserted combinationally.
REQ-026 ack or err with tid matching no POSTED slot shall be ignored.
REQ-027 Simultaneous accept and completion: the freed slot shall not be reused until the next cycle; the accept uses another FREE slot or is refused.

Reset
REQ-029 While rst_i is high, the following shall all be 0: every slot state, wbm_req, texture_data_ack, texture_tag_o and texture_dat_o.
REQ-030 Reset shall abandon in-flight transactions without issuing completion pulses, and responses arriving after reset shall be ignored per REQ-026.

Configuration
REQ-028 With GFX_WBM_MERGE_EN defined, a read whose aligned address equals a PEND or POSTED read slot shall not allocate a slot; the completion of that slot shall emit one pulse per merged request on consecutive cycles. Without the macro, every accepted request allocates its own slot.

Verification
REQ-031 Single read to 0x1000_0040 -> cyc for one cycle with tid {5,0,0}; ack with dat = 0xA5 repeated -> texture_data_ack one cycle later, texture_tag_o = 0, dat_o = 0xA5 pattern.
REQ-032 Four back-to-back reads with BUF_ENTRIES = 4 and no ack -> req_ready_o = 0 after the 4th; a 5th strobe is ignored; ack for tid slot 2 -> req_ready_o = 1 next cycle.
REQ-033 Write with sel = 0x0000_000F and rty on its issue cycle -> the same request is reissued on the next free bus cycle; no rty -> POSTED.
REQ-034 Acks returned out of order (slot 1, then slot 0) -> texture_tag_o = 1, then 0; data matches each.
REQ-035 err on a POSTED slot -> sint_o high in the same cycle, the slot is freed, and a completion pulse is issued; reset asserted with 3 slots POSTED -> no pulses and req_ready_o = 1 after reset.
REQ-036 With GFX_WBM_MERGE_EN defined, two reads to 0x2000 and 0x2010 -> one bus request; a single ack yields two consecutive pulses.
